// File: rtl/mem_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mem_pkg : shared constants for the burst master and its memory    |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
package mem_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic MEM_WR = 1'b1;
  localparam logic MEM_RD = 1'b0;

endpackage
`default_nettype wire

// File: rtl/rd_out_buf.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rd_out_buf : one-entry read-data buffer with valid/ready drain    |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module rd_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             drain_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // A load wins over a drain on the same edge, so the new word stays valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load_i) begin
      r_valid <= 1'b1;
      r_data  <= data_i;
    end else if (drain_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;

endmodule
`default_nettype wire

// File: rtl/mem_burst_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mem_burst_ctrl : burst master driving a valid/ready memory port   |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [WIDTH-1:0]      wr_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic                  r_dir;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_done;

  logic w_accept;
  logic w_buf_free;
  logic w_issue;
  logic w_beat_done;
  logic w_last;
  logic w_rd_load;

  assign w_accept    = (r_state == IDLE) && cmd_valid_i;
  // A read may issue only if its result will have a free slot when it returns.
  assign w_buf_free  = !rd_valid_o || rd_ready_i;
  assign w_issue     = (r_state == ISSUE) &&
                       ((r_dir == MEM_WR) ? wr_valid_i : w_buf_free);
  assign w_beat_done = (r_state == WAIT) && mem_ready_i;
  assign w_last      = (r_cnt == '0);
  assign w_rd_load   = w_beat_done && (r_dir == MEM_RD);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (cmd_valid_i) w_next_state = ISSUE;
      ISSUE:   if (w_issue) w_next_state = WAIT;
      WAIT:    if (mem_ready_i) w_next_state = w_last ? IDLE : ISSUE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    mem_valid_o = 1'b0;
    wr_ready_o  = 1'b0;
    mem_wdata_o = '0;
    case (r_state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      ISSUE: begin
        mem_valid_o = w_issue;
        if ((r_dir == MEM_WR) && wr_valid_i) begin
          wr_ready_o  = 1'b1;
          mem_wdata_o = wr_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dir  <= MEM_RD;
      r_addr <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_beat_done && w_last;
      if (w_accept) begin
        r_dir  <= cmd_wr_rd_i;
        r_addr <= cmd_addr_i;
        r_cnt  <= cmd_len_i;
      end else if (w_beat_done && !w_last) begin
        r_cnt  <= r_cnt - 1'b1;
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign mem_addr_o  = r_addr;
  assign mem_wr_rd_o = r_dir;
  assign done_o      = r_done;

  rd_out_buf #(
    .WIDTH (WIDTH)
  ) u_rd_out_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_rd_load),
    .data_i  (mem_rdata_i),
    .drain_i (rd_ready_i),
    .valid_o (rd_valid_o),
    .data_o  (rd_data_o)
  );

endmodule
`default_nettype wire

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Burst master that sits directly upstream of the single-port handshake memory and drives its valid/wr_rd/addr/wdata port. It accepts one burst command (direction, start address, beat count), then streams write data into the memory or streams read data out of it, one beat at a time, honouring the memory's valid→ready handshake. Read data is presented on a one-entry output buffer with backpressure.

## Interface
- DEPTH, 16, memory depth in words; power of two.
- WIDTH, 8, data width.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- LEN_WIDTH, 4, burst length field; beats = cmd_len_i + 1.

- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake.
- cmd_wr_rd_i  in  1  1 = write burst, 0 = read burst.
- cmd_addr_i  in  ADDR_WIDTH  start address.
- cmd_len_i  in  LEN_WIDTH  beats minus one.
- wr_valid_i / wr_ready_o  in/out  1  write-data stream handshake.
- wr_data_i  in  WIDTH  write beat.
- rd_valid_o / rd_ready_i  out/in  1  read-data stream handshake.
- rd_data_o  out  WIDTH  read beat.
- mem_valid_o, mem_wr_rd_o  out  1  to memory valid_i, wr_rd_i.
- mem_addr_o  out  ADDR_WIDTH  to memory addr_i.
- mem_wdata_o  out  WIDTH  to memory wdata_i.
- mem_rdata_i  in  WIDTH  from memory rdata_o.
- mem_ready_i  in  1  from memory ready_o.
- busy_o  out  1  high whenever state ≠ IDLE.
- done_o  out  1  one-cycle pulse when the last beat completes.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: cmd_ready_o=1. On cmd_valid_i: latch dir, addr_q=cmd_addr_i, cnt_q=cmd_len_i; → ISSUE.
- ISSUE, write: if wr_valid_i, then mem_valid_o=1, wr_ready_o=1, mem_wdata_o=wr_data_i (combinational); → WAIT. Otherwise hold in ISSUE with mem_valid_o=0.
- ISSUE, read: if output buffer empty, or draining this cycle (rd_valid_o & rd_ready_i), then mem_valid_o=1; → WAIT. Otherwise hold.
- WAIT: mem_valid_o=0. On mem_ready_i:
  - read: load rd_data_o=mem_rdata_i and set rd_valid_o.
  - if cnt_q==0: done_o=1, → IDLE.
  - else: cnt_q−1, addr_q+1, → ISSUE.
  - If mem_ready_i is low, remain in WAIT.
- mem_addr_o=addr_q; mem_wr_rd_o=dir_q in all states. Address increments modulo DEPTH: 4'hF+1 → 0.
- Output buffer: rd_valid_o clears on rd_ready_i unless reloaded the same edge; a simultaneous drain and load keeps rd_valid_o=1 with new data.
- Command is ignored while busy (cmd_ready_o=0).
- Reset (asynchronous, any state): state=IDLE; cnt_q, addr_q, dir_q, rd_data_o=0; rd_valid_o, done_o=0. The burst in flight is aborted with no done_o pulse.

## Timing
- Command accept edge E0 → mem_valid_o high in cycle after E0 (ISSUE), sampled by memory at E1.
- Memory ready/rdata valid after E1 (WAIT); read data captured at E2; rd_valid_o high after E2.
- Steady state: 2 cycles per beat with no stalls; an N-beat burst takes 2N cycles from accept to done_o.
- done_o is asserted the cycle after the final WAIT edge and lasts 1 cycle. cmd_ready_o returns in the same cycle, so back-to-back commands are allowed.
- mem_valid_o is never high for two consecutive cycles.
- Outputs after reset: cmd_ready_o=1, all others 0.

## Structure
- Shared package mem_pkg:
  - state encoding localparams (IDLE=0, ISSUE=1, WAIT=2).
  - default DEPTH/WIDTH.
  - direction constants (MEM_WR=1, MEM_RD=0).
- Sub-module rd_out_buf holds the one-entry read buffer (load/drain/valid logic).
- The FSM and counters live in mem_burst_ctrl.

## Test plan
- Write burst: addr=3, len=3, data 0xA0..0xA3 with wr_valid_i held high → four mem_valid_o pulses at addr 3..6, 2 cycles apart; done_o at cycle 8.
- Read burst: same range with rd_ready_i=1 → rd_data_o=0xA0,0xA1,0xA2,0xA3 in order; done_o once.
- Wrap: write addr=14, len=3 → mem_addr_o sequence 14,15,0,1; read back matches.
- Backpressure: read len=2 with rd_ready_i=0 for 5 cycles → no second mem_valid_o until drain; no data lost or duplicated.
- Write starvation: wr_valid_i low 4 cycles mid-burst → FSM holds ISSUE, mem_valid_o=0, beat count unchanged.
- Reset mid-burst: assert rst_i asynchronously in WAIT of beat 2 → outputs zero immediately, cmd_ready_o=1, no done_o pulse; a new command afterwards executes normally.
